mix_pipe: RTL and testbench
===========================

MIX_PIPE -- requirements
Module: mix_pipe

Interface
REQ-001 SHALL have parameter W, default 64: word width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter LANES, default 4: number of parallel MIX lanes j=0..LANES-1; legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port x0_i, input, LANES*W bits: lane j occupies bits [j*W +: W].
REQ-006 SHALL have port x1_i, input, LANES*W bits: second input word per lane, same packing as x0_i.
REQ-007 SHALL have port d_i, input, 8 bits: round number.
REQ-008 SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts an input beat.
REQ-010 SHALL have port y0_o, output, LANES*W bits: first result word per lane.
REQ-011 SHALL have port y1_o, output, LANES*W bits: second result word per lane.
REQ-012 SHALL have port out_valid, output, 1 bit: output beat valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the output beat.

Function
REQ-014 SHALL compute, per lane j: y0 = (x0 + x1) mod 2^W and y1 = rol(x1, R[d%8][j] mod W) XOR y0.
REQ-015 SHALL use rotation table R, rows d%8 = 0..7, columns j = 0..7:
  0: 55,43,37,40,16,22,38,12 | 1: 25,25,46,13,14,13,52,57 | 2: 33,8,18,57,21,12,32,54 | 3: 34,43,25,60,44,9,59,34
  4: 28,7,47,48,51,9,35,41 | 5: 17,6,18,25,43,42,40,15 | 6: 58,7,32,45,19,18,2,56 | 7: 47,49,27,58,37,48,53,56
REQ-016 SHALL be a two-stage pipeline. Stage 1 registers the sum, x1 and the per-lane rotation amounts; stage 2 registers the rotate/XOR result.
REQ-017 SHALL have a latency of exactly 2 cycles from input handshake to out_valid when out_ready stays high; throughput SHALL be one beat per cycle.
REQ-018 SHALL transfer an input only when in_valid && in_ready are both high, and an output only when out_valid && out_ready are both high.
REQ-019 SHALL drive in_ready = !v1 || !v2 || out_ready, where v1 and v2 are the stage valid flags; in_ready SHALL NOT depend on in_valid.
REQ-020 SHALL hold y0_o, y1_o and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL, under backpressure, fill both stages and then stall with no beat lost, duplicated or reordered.
REQ-022 SHALL accept a new input in the same cycle a stalled output is consumed, with no bubble.
REQ-023 SHALL discard the carry out of bit W-1; a rotation amount of 0 SHALL pass x1 through unrotated.

Reset
REQ-024 SHALL, while rst_n is low, clear v1, v2 and out_valid to 0 and clear y0_o and y1_o to 0 asynchronously.
REQ-025 SHALL drive in_ready to 1 while in reset and in the first cycle after reset release.
REQ-026 SHALL drop any beat in flight when reset is asserted mid-operation, with no output produced for it after release.

Configuration
REQ-027 SHALL, when macro MIX_PIPE_INV_EN is defined, add input port mode_i (1 bit), sampled together with the input beat and carried through the pipeline alongside it.
REQ-028 SHALL, with MIX_PIPE_INV_EN defined and mode_i=1, compute the inverse MIX per lane: t = ror(x1 XOR x0, R[d%8][j] mod W), y1 = t, y0 = (x0 - t) mod 2^W. Inverse mode SHALL have the same latency and handshake as forward mode.
REQ-029 SHALL, without MIX_PIPE_INV_EN, omit mode_i and implement forward mode only.

Verification
REQ-030 Bench SHALL check basic forward: W=64, lane0 x0=1, x1=1, d=0 -> y0=0x2, y1=0x0080000000000002, out_valid exactly 2 cycles after accept.
REQ-031 Bench SHALL check carry wrap: x0=0xFFFFFFFFFFFFFFFF, x1=1, d=9, lane1 -> y0=0, y1=rol(1,25)=0x0000000002000000.
REQ-032 Bench SHALL check backpressure: out_ready=0, five back-to-back beats -> in_ready drops after 2 accepts. Then out_ready=1 -> all 5 results emerge in order, one per cycle.
REQ-033 Bench SHALL check reset mid-operation: rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, and no output after release.
REQ-034 Bench SHALL check inverse, with MIX_PIPE_INV_EN: random x0, x1, d passed through forward then inverse -> original x0, x1 recovered on all lanes.
REQ-035 Bench SHALL check W=32, LANES=8, d=7, lane7 with x0=0, x1=1 -> y1 = rol(1,56 mod 32 = 24) XOR 1 = 0x01000001.

Source files
------------

// File: rtl/mix_pipe.sv
// ============================================================================
// Module   : mix_pipe
// Two-stage valid/ready MIX pipeline over LANES words of W bits.
// Optional inverse MIX (mode_i port) when MIX_PIPE_INV_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mix_pipe #(
    parameter int W     = 64,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LANES*W-1:0] x0_i,
    input  logic [LANES*W-1:0] x1_i,
    input  logic [7:0]         d_i,
    input  logic               in_valid,
    output logic               in_ready,
`ifdef MIX_PIPE_INV_EN
    input  logic               mode_i,
`endif
    output logic [LANES*W-1:0] y0_o,
    output logic [LANES*W-1:0] y1_o,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int RW = $clog2(W);

    // Low RW bits of a 6-bit table entry equal the entry mod W for W = 32/64.
    function automatic logic [RW-1:0] rot_amt(input logic [2:0] row, input int lane);
        logic [47:0] v;
        case (row)
            3'd0:    v = {6'd12, 6'd38, 6'd22, 6'd16, 6'd40, 6'd37, 6'd43, 6'd55};
            3'd1:    v = {6'd57, 6'd52, 6'd13, 6'd14, 6'd13, 6'd46, 6'd25, 6'd25};
            3'd2:    v = {6'd54, 6'd32, 6'd12, 6'd21, 6'd57, 6'd18, 6'd8,  6'd33};
            3'd3:    v = {6'd34, 6'd59, 6'd9,  6'd44, 6'd60, 6'd25, 6'd43, 6'd34};
            3'd4:    v = {6'd41, 6'd35, 6'd9,  6'd51, 6'd48, 6'd47, 6'd7,  6'd28};
            3'd5:    v = {6'd15, 6'd40, 6'd42, 6'd43, 6'd25, 6'd18, 6'd6,  6'd17};
            3'd6:    v = {6'd56, 6'd2,  6'd18, 6'd19, 6'd45, 6'd32, 6'd7,  6'd58};
            default: v = {6'd56, 6'd53, 6'd48, 6'd37, 6'd58, 6'd27, 6'd49, 6'd47};
        endcase
        return v[lane*6 +: RW];
    endfunction

    function automatic logic [W-1:0] rol(input logic [W-1:0] x, input logic [RW-1:0] r);
        logic [2*W-1:0] t;
        t = {x, x} << r;
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] ror(input logic [W-1:0] x, input logic [RW-1:0] r);
        logic [2*W-1:0] t;
        t = {x, x} >> r;
        return t[W-1:0];
    endfunction

    logic                  r_v1;
    logic                  r_v2;
    logic [LANES*W-1:0]    r_a;
    logic [LANES*W-1:0]    r_b;
    logic [LANES*RW-1:0]   r_amt;
    logic [LANES*W-1:0]    r_y0;
    logic [LANES*W-1:0]    r_y1;
    logic                  r_mode;

    logic [LANES*W-1:0]    w_a;
    logic [LANES*W-1:0]    w_b;
    logic [LANES*RW-1:0]   w_amt;
    logic [LANES*W-1:0]    w_y0;
    logic [LANES*W-1:0]    w_y1;
    logic [2:0]            w_row;
    logic                  w_mode;
    logic                  w_adv1;
    logic                  w_adv2;

`ifdef MIX_PIPE_INV_EN
    assign w_mode = mode_i;
`else
    assign w_mode = 1'b0;
`endif

    assign w_row  = 3'(d_i % 8'd8);
    assign w_adv2 = !r_v2 || out_ready;
    assign w_adv1 = !r_v1 || !r_v2 || out_ready;

    // Stage 1 holds (sum, x1) for forward and (x0, x0^x1) for inverse.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [W-1:0] w_x0;
        logic [W-1:0] w_x1;
        logic [W-1:0] w_sa;
        logic [W-1:0] w_sb;
        logic [RW-1:0] w_r;
        logic [W-1:0] w_t;

        assign w_x0 = x0_i[j*W +: W];
        assign w_x1 = x1_i[j*W +: W];
        assign w_amt[j*RW +: RW] = rot_amt(w_row, j);

        assign w_sa = r_a[j*W +: W];
        assign w_sb = r_b[j*W +: W];
        assign w_r  = r_amt[j*RW +: RW];

`ifdef MIX_PIPE_INV_EN
        assign w_a[j*W +: W]  = w_mode ? w_x0 : w_x0 + w_x1;
        assign w_b[j*W +: W]  = w_mode ? (w_x0 ^ w_x1) : w_x1;
        assign w_t            = ror(w_sb, w_r);
        assign w_y0[j*W +: W] = r_mode ? w_sa - w_t : w_sa;
        assign w_y1[j*W +: W] = r_mode ? w_t : (rol(w_sb, w_r) ^ w_sa);
`else
        assign w_a[j*W +: W]  = w_x0 + w_x1;
        assign w_b[j*W +: W]  = w_x1;
        assign w_t            = rol(w_sb, w_r);
        assign w_y0[j*W +: W] = w_sa;
        assign w_y1[j*W +: W] = w_t ^ w_sa;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_amt  <= '0;
            r_mode <= 1'b0;
            r_y0   <= '0;
            r_y1   <= '0;
        end else begin
            if (w_adv1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_a    <= w_a;
                    r_b    <= w_b;
                    r_amt  <= w_amt;
                    r_mode <= w_mode;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_y0 <= w_y0;
                    r_y1 <= w_y1;
                end
            end
        end
    end

    assign in_ready  = w_adv1;
    assign out_valid = r_v2;
    assign y0_o      = r_y0;
    assign y1_o      = r_y1;

endmodule

`default_nettype wire

// File: tb/tb_mix_pipe.sv
// Self-checking bench for mix_pipe: scoreboard model plus directed literal cases.
`default_nettype none

module tb_mix_pipe;

    localparam int AW = 64;
    localparam int AL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [255:0] x0 = '0, x1 = '0, y0, y1;
    logic [7:0]   d = '0;
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic         mode = 1'b0;

    logic [255:0] b_x0 = '0, b_x1 = '0, b_y0, b_y1;
    logic [7:0]   b_d = '0;
    logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
    logic         b_mode = 1'b0;

    mix_pipe #(.W(AW), .LANES(AL)) dut_a (
        .clk(clk), .rst_n(rst_n), .x0_i(x0), .x1_i(x1), .d_i(d),
        .in_valid(in_valid), .in_ready(in_ready),
`ifdef MIX_PIPE_INV_EN
        .mode_i(mode),
`endif
        .y0_o(y0), .y1_o(y1), .out_valid(out_valid), .out_ready(out_ready)
    );

    mix_pipe #(.W(32), .LANES(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .x0_i(b_x0), .x1_i(b_x1), .d_i(b_d),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
`ifdef MIX_PIPE_INV_EN
        .mode_i(b_mode),
`endif
        .y0_o(b_y0), .y1_o(b_y1), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    int R [8][8] = '{
        '{55,43,37,40,16,22,38,12}, '{25,25,46,13,14,13,52,57},
        '{33, 8,18,57,21,12,32,54}, '{34,43,25,60,44, 9,59,34},
        '{28, 7,47,48,51, 9,35,41}, '{17, 6,18,25,43,42,40,15},
        '{58, 7,32,45,19,18, 2,56}, '{47,49,27,58,37,48,53,56}};

    typedef struct {
        logic [255:0] e0;
        logic [255:0] e1;
        int           acc;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rol64(input logic [63:0] x, input int r);
        return (r == 0) ? x : ((x << r) | (x >> (64 - r)));
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int r);
        return (r == 0) ? x : ((x >> r) | (x << (64 - r)));
    endfunction

    function automatic void model(input logic [255:0] a, input logic [255:0] b,
                                  input logic [7:0] dd, input logic m,
                                  output logic [255:0] e0, output logic [255:0] e1);
        logic [63:0] xa, xb, s, t;
        int r;
        e0 = '0;
        e1 = '0;
        for (int j = 0; j < AL; j++) begin
            xa = a[j*64 +: 64];
            xb = b[j*64 +: 64];
            r  = R[dd % 8][j] % 64;
            if (!m) begin
                s = xa + xb;
                e0[j*64 +: 64] = s;
                e1[j*64 +: 64] = rol64(xb, r) ^ s;
            end else begin
                t = ror64(xa ^ xb, r);
                e1[j*64 +: 64] = t;
                e0[j*64 +: 64] = xa - t;
            end
        end
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic send(input logic [255:0] a, input logic [255:0] b,
                        input logic [7:0] dd, input logic m);
        logic got;
        got = 1'b0;
        x0 = a; x1 = b; d = dd; mode = m; in_valid = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_out(output logic [255:0] c0, output logic [255:0] c1);
        logic got;
        got = 1'b0;
        c0 = '0;
        c1 = '0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                c0 = y0;
                c1 = y1;
            end
        end
        if (!got) chk("wait_out_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    logic [255:0] bx0 [5];
    logic [255:0] bx1 [5];
    logic [7:0]   bd  [5];

    initial begin
        logic [255:0] e0, e1, c0, c1, o0, o1;
        int acc, nout, bi;
        logic got;
        exp_t it;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    q.delete();
                    chk("rst_out_valid", out_valid, 0);
                end else begin
                    chk("in_ready", in_ready, (q.size() < 2) || out_ready);
                    chk("out_valid", out_valid, (q.size() > 0) && (cyc >= q[0].acc + 1));
                    if (out_valid && q.size() > 0) begin
                        chk("sb_y0", y0, q[0].e0);
                        chk("sb_y1", y1, q[0].e1);
                        if (out_ready) void'(q.pop_front());
                    end
                    if (in_valid && in_ready) begin
                        model(x0, x1, d, mode, it.e0, it.e1);
                        it.acc = cyc + 1;
                        q.push_back(it);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_y0", y0, 0);
        chk("reset_y1", y1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Basic forward and 2-cycle latency.
        send({4{64'd1}}, {4{64'd1}}, 8'd0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_out_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_out_valid", out_valid, 1);
        chk("basic_y0_lane0", y0[63:0], 64'h2);
        chk("basic_y1_lane0", y1[63:0], 64'h0080000000000002);
        @(posedge clk); #1;

        // Carry wrap, d=9 selects row 1.
        send({4{64'hFFFFFFFFFFFFFFFF}}, {4{64'd1}}, 8'd9, 1'b0);
        in_valid = 1'b0;
        wait_out(c0, c1);
        chk("wrap_y0_lane1", c0[127:64], 64'h0);
        chk("wrap_y1_lane1", c1[127:64], 64'h0000000002000000);

        // Backpressure: five beats against a stalled output.
        for (int i = 0; i < 5; i++) begin
            bx0[i] = rnd256(); bx1[i] = rnd256(); bd[i] = 8'($urandom);
        end
        out_ready = 1'b0;
        bi = 0; acc = 0;
        x0 = bx0[0]; x1 = bx1[0]; d = bd[0]; mode = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
            if (got) begin
                acc++; bi++;
                x0 = bx0[bi]; x1 = bx1[bi]; d = bd[bi];
            end
        end
        chk("bp_accepts", acc, 2);
        chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        nout = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) nout++;
            got = in_valid && in_ready;
            @(posedge clk); #1;
            if (got) bi++;
            if (bi < 5) begin
                x0 = bx0[bi]; x1 = bx1[bi]; d = bd[bi];
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("bp_streak", nout, 5);
        chk("bp_all_accepted", bi, 5);
        repeat (3) @(posedge clk); #1;

        // Reset with two beats in flight.
        send(rnd256(), rnd256(), 8'd3, 1'b0);
        send(rnd256(), rnd256(), 8'd4, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        nout = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) nout++;
        end
        chk("midrst_no_output", nout, 0);
        @(posedge clk); #1;

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            x0 = rnd256(); x1 = rnd256(); d = 8'($urandom);
`ifdef MIX_PIPE_INV_EN
            mode = 1'($urandom);
`endif
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
        repeat (6) @(posedge clk); #1;

`ifdef MIX_PIPE_INV_EN
        // Forward then inverse must restore the original words.
        for (int t = 0; t < 6; t++) begin
            o0 = rnd256(); o1 = rnd256(); d = 8'($urandom);
            e0 = {56'd0, d};
            send(o0, o1, d, 1'b0);
            in_valid = 1'b0;
            wait_out(c0, c1);
            send(c0, c1, e0[7:0], 1'b1);
            in_valid = 1'b0;
            wait_out(e0, e1);
            chk("inv_x0", e0, o0);
            chk("inv_x1", e1, o1);
        end
        mode = 1'b0;
`endif

        // W=32, LANES=8, d=7: lane 7 rotates by 56 mod 32 = 24.
        b_x0 = '0; b_x1 = {8{32'd1}}; b_d = 8'd7; b_in_valid = 1'b1;
        @(negedge clk);
        chk("w32_in_ready", b_in_ready, 1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("w32_out_valid", b_out_valid, 1);
        chk("w32_y0_lane7", b_y0[7*32 +: 32], 32'h1);
        chk("w32_y1_lane7", b_y1[7*32 +: 32], 32'h01000001);

        repeat (4) @(posedge clk); #1;
        chk("drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
